axi_mem_responder: RTL and testbench

AXI-style memory responder (slave) that answers the core's memory arbiter on the AW/W/B and AR/R channels. It is used in simulation and FPGA bring-up as the backing store behind the core. The block holds a word-addressed RAM and serves single-outstanding read and write bursts with a configurable read latency. Read and write channels run independently.

---
 rtl/axi_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: word-addressed RAM behind an AXI-style slave port.
// Single-outstanding read and write bursts; read and write channels are fully
// independent. First read beat appears READ_LATENCY cycles after AR handshake.
// Optional build macro AXI_MEM_PROTOCOL_CHECK_EN adds a sticky protocol error
// flag on the write data channel; without it proto_err is tied low.
`timescale 1ns/1ps
module axi_mem_responder #(
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH_LOG2   = 14,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  AWREADY,
   input  logic                  AWVALID,
   input  logic [3:0]            AWID,
   input  logic [3:0]            AWLEN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   output logic                  WREADY,
   input  logic                  WVALID,
   input  logic                  WLAST,
   input  logic [3:0]            WID,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  BREADY,
   output logic                  BVALID,
   output logic [3:0]            BID,
   output logic                  ARREADY,
   input  logic                  ARVALID,
   input  logic [3:0]            ARID,
   input  logic [3:0]            ARLEN,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  RREADY,
   output logic                  RVALID,
   output logic                  RLAST,
   output logic [3:0]            RID,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  proto_err
);

   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} r_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

   logic [DATA_WIDTH-1:0] mem_r [0:(1 << DEPTH_LOG2) - 1];

   // read side state
   r_state_t               r_state_r, r_next_s;
   logic                   arready_r, arready_s;
   logic                   rvalid_r, rvalid_s;
   logic                   rlast_r, rlast_s;
   logic [3:0]             rid_r, rid_s;
   logic [3:0]             rlen_r, rlen_s;
   logic [3:0]             rbeat_r, rbeat_s;
   logic [LAT_W-1:0]       rlat_r, rlat_s;
   logic [DEPTH_LOG2-1:0]  raddr_r, raddr_s;
   logic [DEPTH_LOG2-1:0]  ridx_s;
   logic                   rload_s;
   logic [DATA_WIDTH-1:0]  rdata_r;

   // write side state
   w_state_t               w_state_r, w_next_s;
   logic                   awready_r, awready_s;
   logic                   wready_r, wready_s;
   logic                   bvalid_r, bvalid_s;
   logic [3:0]             bid_r, bid_s;
   logic [3:0]             wlen_r, wlen_s;
   logic [3:0]             wbeat_r, wbeat_s;
   logic [DEPTH_LOG2-1:0]  waddr_r, waddr_s;
   logic [DEPTH_LOG2-1:0]  widx_s;
   logic                   we_s;

   // Read FSM next state and next registered outputs; rload_s fetches the beat shown next cycle
   always_comb begin
      r_next_s  = r_state_r;
      arready_s = arready_r;
      rvalid_s  = rvalid_r;
      rlast_s   = rlast_r;
      rid_s     = rid_r;
      rlen_s    = rlen_r;
      rbeat_s   = rbeat_r;
      rlat_s    = rlat_r;
      raddr_s   = raddr_r;
      rload_s   = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            if (ARVALID) begin
               r_next_s  = R_WAIT;
               arready_s = 1'b0;
               rid_s     = ARID;
               raddr_s   = ARADDR[DEPTH_LOG2-1:0];
               rlen_s    = ARLEN;
               rbeat_s   = 4'd0;
               rlat_s    = LAT_INIT;
            end else begin
               r_next_s  = R_IDLE;
            end
         end
         R_WAIT: begin
            if (rlat_r == {LAT_W{1'b0}}) begin
               r_next_s = R_BURST;
               rvalid_s = 1'b1;
               rlast_s  = (rlen_r == 4'd0);
               rload_s  = 1'b1;
            end else begin
               rlat_s   = rlat_r - {{(LAT_W-1){1'b0}}, 1'b1};
            end
         end
         R_BURST: begin
            if (RREADY) begin
               if (rbeat_r == rlen_r) begin
                  r_next_s  = R_IDLE;
                  rvalid_s  = 1'b0;
                  rlast_s   = 1'b0;
                  arready_s = 1'b1;
               end else begin
                  rbeat_s   = rbeat_r + 4'd1;
                  rlast_s   = ((rbeat_r + 4'd1) == rlen_r);
                  rload_s   = 1'b1;
               end
            end else begin
               r_next_s = R_BURST;
            end
         end
         default: begin
            r_next_s  = R_IDLE;
            arready_s = 1'b1;
            rvalid_s  = 1'b0;
            rlast_s   = 1'b0;
         end
      endcase
      // burst index wraps naturally in the DEPTH_LOG2-bit adder
      ridx_s = raddr_r + DEPTH_LOG2'(rbeat_s);
   end

   // Read FSM registers, including the registered RAM read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b1;
         rvalid_r  <= 1'b0;
         rlast_r   <= 1'b0;
         rid_r     <= 4'd0;
         rlen_r    <= 4'd0;
         rbeat_r   <= 4'd0;
         rlat_r    <= {LAT_W{1'b0}};
         raddr_r   <= {DEPTH_LOG2{1'b0}};
         rdata_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         r_state_r <= r_next_s;
         arready_r <= arready_s;
         rvalid_r  <= rvalid_s;
         rlast_r   <= rlast_s;
         rid_r     <= rid_s;
         rlen_r    <= rlen_s;
         rbeat_r   <= rbeat_s;
         rlat_r    <= rlat_s;
         raddr_r   <= raddr_s;
         if (rload_s) begin
            rdata_r <= mem_r[ridx_s];
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   // Write FSM next state; burst length comes from the beat counter, never from WLAST
   always_comb begin
      w_next_s  = w_state_r;
      awready_s = awready_r;
      wready_s  = wready_r;
      bvalid_s  = bvalid_r;
      bid_s     = bid_r;
      wlen_s    = wlen_r;
      wbeat_s   = wbeat_r;
      waddr_s   = waddr_r;
      we_s      = 1'b0;
      widx_s    = waddr_r + DEPTH_LOG2'(wbeat_r);
      case (w_state_r)
         W_IDLE: begin
            if (AWVALID) begin
               w_next_s  = W_DATA;
               awready_s = 1'b0;
               wready_s  = 1'b1;
               bid_s     = AWID;
               waddr_s   = AWADDR[DEPTH_LOG2-1:0];
               wlen_s    = AWLEN;
               wbeat_s   = 4'd0;
            end else begin
               w_next_s  = W_IDLE;
            end
         end
         W_DATA: begin
            if (WVALID) begin
               we_s = 1'b1;
               if (wbeat_r == wlen_r) begin
                  w_next_s = W_RESP;
                  wready_s = 1'b0;
                  bvalid_s = 1'b1;
               end else begin
                  wbeat_s  = wbeat_r + 4'd1;
               end
            end else begin
               w_next_s = W_DATA;
            end
         end
         W_RESP: begin
            if (BREADY) begin
               w_next_s  = W_IDLE;
               bvalid_s  = 1'b0;
               awready_s = 1'b1;
            end else begin
               w_next_s  = W_RESP;
            end
         end
         default: begin
            w_next_s  = W_IDLE;
            awready_s = 1'b1;
            wready_s  = 1'b0;
            bvalid_s  = 1'b0;
         end
      endcase
   end

   // Write FSM registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_r <= W_IDLE;
         awready_r <= 1'b1;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bid_r     <= 4'd0;
         wlen_r    <= 4'd0;
         wbeat_r   <= 4'd0;
         waddr_r   <= {DEPTH_LOG2{1'b0}};
      end else begin
         w_state_r <= w_next_s;
         awready_r <= awready_s;
         wready_r  <= wready_s;
         bvalid_r  <= bvalid_s;
         bid_r     <= bid_s;
         wlen_r    <= wlen_s;
         wbeat_r   <= wbeat_s;
         waddr_r   <= waddr_s;
      end
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[widx_s] <= WDATA;
      end
   end

   assign AWREADY = awready_r;
   assign WREADY  = wready_r;
   assign BVALID  = bvalid_r;
   assign BID     = bid_r;
   assign ARREADY = arready_r;
   assign RVALID  = rvalid_r;
   assign RLAST   = rlast_r;
   assign RID     = rid_r;
   assign RDATA   = rdata_r;

   // address bits above the RAM index are ignored
   logic unused_addr_s;
   assign unused_addr_s = ^{ARADDR[ADDR_WIDTH-1:DEPTH_LOG2], AWADDR[ADDR_WIDTH-1:DEPTH_LOG2]};

`ifdef AXI_MEM_PROTOCOL_CHECK_EN
   logic err_id_s, err_early_s, err_missing_s, err_idle_s;
   logic proto_err_r;

   // Classify write-channel protocol violations for the current cycle
   always_comb begin
      err_id_s      = 1'b0;
      err_early_s   = 1'b0;
      err_missing_s = 1'b0;
      err_idle_s    = 1'b0;
      if (WVALID && (w_state_r == W_DATA)) begin
         err_id_s      = (WID != bid_r);
         err_early_s   = WLAST && (wbeat_r != wlen_r);
         err_missing_s = !WLAST && (wbeat_r == wlen_r);
      end else if (WVALID && (w_state_r == W_IDLE)) begin
         err_idle_s    = 1'b1;
      end else begin
         err_idle_s    = 1'b0;
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proto_err_r <= 1'b0;
      end else if (err_id_s || err_early_s || err_missing_s || err_idle_s) begin
         proto_err_r <= 1'b1;
      end else begin
         proto_err_r <= proto_err_r;
      end
   end

`ifdef SIMULATION
   // Report each violation with its cause
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (err_id_s)      $error("%0t: axi_mem_responder WID mismatch", $time);
         if (err_early_s)   $error("%0t: axi_mem_responder WLAST before final beat", $time);
         if (err_missing_s) $error("%0t: axi_mem_responder WLAST missing on final beat", $time);
         if (err_idle_s)    $error("%0t: axi_mem_responder WVALID with no open burst", $time);
      end
   end
`endif

   assign proto_err = proto_err_r;
`else
   logic unused_proto_s;
   assign unused_proto_s = ^{WID, WLAST};
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: writes, reads, backpressure, address
// wrap, reset mid-burst and the WLAST protocol check.
`timescale 1ns/1ps
module tb_axi_mem_responder;

   localparam int AW = 26;
   localparam int DW = 32;
   localparam int LAT = 2;
`ifdef AXI_MEM_PROTOCOL_CHECK_EN
   localparam logic PCHK = 1'b1;
`else
   localparam logic PCHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          AWREADY, AWVALID = 1'b0;
   logic [3:0]    AWID = 4'd0, AWLEN = 4'd0;
   logic [AW-1:0] AWADDR = '0;
   logic          WREADY, WVALID = 1'b0, WLAST = 1'b0;
   logic [3:0]    WID = 4'd0;
   logic [DW-1:0] WDATA = '0;
   logic          BREADY = 1'b1, BVALID;
   logic [3:0]    BID;
   logic          ARREADY, ARVALID = 1'b0;
   logic [3:0]    ARID = 4'd0, ARLEN = 4'd0;
   logic [AW-1:0] ARADDR = '0;
   logic          RREADY = 1'b1, RVALID, RLAST;
   logic [3:0]    RID;
   logic [DW-1:0] RDATA;
   logic          proto_err;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] wr_data [8];
   logic [DW-1:0] exp_data [8];

   axi_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(14), .READ_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .AWREADY(AWREADY), .AWVALID(AWVALID), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WREADY(WREADY), .WVALID(WVALID), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .BREADY(BREADY), .BVALID(BVALID), .BID(BID),
      .ARREADY(ARREADY), .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " awready"}, {31'd0, AWREADY}, 32'd1);
      check({tag, " arready"}, {31'd0, ARREADY}, 32'd1);
      check({tag, " wready"},  {31'd0, WREADY},  32'd0);
      check({tag, " bvalid"},  {31'd0, BVALID},  32'd0);
      check({tag, " rvalid"},  {31'd0, RVALID},  32'd0);
      check({tag, " rlast"},   {31'd0, RLAST},   32'd0);
      check({tag, " bid"},     {28'd0, BID},     32'd0);
      check({tag, " rid"},     {28'd0, RID},     32'd0);
      check({tag, " rdata"},   RDATA,            32'd0);
      check({tag, " proto"},   {31'd0, proto_err}, 32'd0);
   endtask

   // write burst with data from wr_data; bad_beat >= 0 also raises WLAST on that beat
   task automatic axi_write(input logic [AW-1:0] addr, input logic [3:0] id,
                            input logic [3:0] len, input int bad_beat);
      AWVALID = 1'b1; AWADDR = addr; AWID = id; AWLEN = len;
      check("aw_ready_idle", {31'd0, AWREADY}, 32'd1);
      tick();
      AWVALID = 1'b0;
      check("aw_ready_busy", {31'd0, AWREADY}, 32'd0);
      for (int b = 0; b <= int'(len); b++) begin
         WVALID = 1'b1; WID = id; WDATA = wr_data[b];
         WLAST = (b == int'(len)) || (b == bad_beat);
         check("w_ready", {31'd0, WREADY}, 32'd1);
         check("b_not_early", {31'd0, BVALID}, 32'd0);
         tick();
         if (bad_beat >= 0 && b >= bad_beat)
            check("proto_err_set", {31'd0, proto_err}, {31'd0, PCHK});
      end
      WVALID = 1'b0; WLAST = 1'b0;
      check("b_valid", {31'd0, BVALID}, 32'd1);
      check("b_id", {28'd0, BID}, {28'd0, id});
      check("w_ready_done", {31'd0, WREADY}, 32'd0);
      tick();
      check("b_one_cycle", {31'd0, BVALID}, 32'd0);
      check("aw_ready_back", {31'd0, AWREADY}, 32'd1);
   endtask

   // read burst checked against exp_data; RREADY low for stall_n cycles on stall_beat
   task automatic axi_read(input logic [AW-1:0] addr, input logic [3:0] id,
                           input logic [3:0] len, input int stall_beat, input int stall_n);
      ARVALID = 1'b1; ARADDR = addr; ARID = id; ARLEN = len; RREADY = 1'b1;
      check("ar_ready_idle", {31'd0, ARREADY}, 32'd1);
      tick();
      ARVALID = 1'b0;
      check("ar_ready_busy", {31'd0, ARREADY}, 32'd0);
      for (int c = 0; c < LAT; c++) begin
         check("r_latency", {31'd0, RVALID}, 32'd0);
         tick();
      end
      for (int b = 0; b <= int'(len); b++) begin
         if (b == stall_beat) begin
            RREADY = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               check("r_hold_valid", {31'd0, RVALID}, 32'd1);
               check("r_hold_data", RDATA, exp_data[b]);
               check("r_hold_last", {31'd0, RLAST}, {31'd0, (b == int'(len))});
               tick();
            end
            RREADY = 1'b1;
         end
         check("r_valid", {31'd0, RVALID}, 32'd1);
         check("r_data", RDATA, exp_data[b]);
         check("r_id", {28'd0, RID}, {28'd0, id});
         check("r_last", {31'd0, RLAST}, {31'd0, (b == int'(len))});
         tick();
      end
      check("r_done", {31'd0, RVALID}, 32'd0);
      check("ar_ready_back", {31'd0, ARREADY}, 32'd1);
   endtask

   initial begin
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // 1: four-beat write at 0x10
      for (int i = 0; i < 8; i++) wr_data[i] = 32'hA0 + i;
      axi_write(26'h10, 4'd3, 4'd3, -1);

      // 2: read it back without stalls
      for (int i = 0; i < 8; i++) exp_data[i] = 32'hA0 + i;
      axi_read(26'h10, 4'd5, 4'd3, -1, 0);

      // 3: same read with a 3-cycle stall on beat 1
      axi_read(26'h10, 4'd5, 4'd3, 1, 3);

      // 4: wrap at the top of the RAM
      wr_data[0] = 32'h11; wr_data[1] = 32'h22;
      axi_write(26'h3FFF, 4'd1, 4'd1, -1);
      exp_data[0] = 32'h11; exp_data[1] = 32'h22;
      axi_read(26'h3FFF, 4'd2, 4'd1, -1, 0);
      exp_data[0] = 32'h22;
      axi_read(26'h0, 4'd4, 4'd0, -1, 0);

      // 5: reset during beat 2 of an 8-beat read and an 8-beat write
      ARVALID = 1'b1; ARADDR = 26'h10; ARID = 4'd6; ARLEN = 4'd7; RREADY = 1'b1;
      tick();
      ARVALID = 1'b0;
      tick();
      AWVALID = 1'b1; AWADDR = 26'h100; AWID = 4'd7; AWLEN = 4'd7;
      tick();
      AWVALID = 1'b0;
      check("mid_r_beat0", RDATA, 32'hA0);
      WVALID = 1'b1; WID = 4'd7; WLAST = 1'b0; WDATA = 32'hB0;
      tick();
      WDATA = 32'hB1;
      tick();
      check("mid_r_beat2", RDATA, 32'hA2);
      check("mid_w_ready", {31'd0, WREADY}, 32'd1);
      WDATA = 32'hB2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      WVALID = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_bvalid_after_rst", {31'd0, BVALID}, 32'd0);
         check("no_rvalid_after_rst", {31'd0, RVALID}, 32'd0);
      end
      exp_data[0] = 32'hB0; exp_data[1] = 32'hB1;
      axi_read(26'h100, 4'd8, 4'd1, -1, 0);
      exp_data[0] = 32'hA0;
      axi_read(26'h10, 4'd9, 4'd0, -1, 0);

      // 6: early WLAST on beat 1; response still after four beats
      for (int i = 0; i < 8; i++) wr_data[i] = 32'hC0 + i;
      axi_write(26'h200, 4'd2, 4'd3, 1);
      tick();
      check("proto_err_sticky", {31'd0, proto_err}, {31'd0, PCHK});
      for (int i = 0; i < 8; i++) exp_data[i] = 32'hC0 + i;
      axi_read(26'h200, 4'd1, 4'd3, -1, 0);
      rst = 1'b1;
      tick();
      check("proto_err_cleared", {31'd0, proto_err}, 32'd0);
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
